mte_frame_sequencer: RTL and testbench
======================================

Name: mte_frame_sequencer

Overview:
- Controller that sequences the MAC-then-encrypt byte datapath over a frame of 1..MAX_LEN bytes.
- Accepts a frame request with mode and length, then streams input bytes into the datapath under credit control.
- Captures datapath results after the fixed pipeline latency into an output FIFO and presents them on a ready/valid stream.
- Accumulates the per-byte MAC-compare flag and reports frame completion and MAC validity.

Parameters:
- W, 8, byte/data width
- MAX_LEN, 32, maximum frame length in bytes
- DP_LAT, 2, fixed datapath latency in cycles from issue to result (≥1)
- FIFO_DEPTH, 4, output FIFO entries (must be ≥ DP_LAT+1)

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  frame request, sampled only in IDLE
- mode  in  1  1=encrypt, 0=decrypt; latched on accepted start
- len  in  6  frame length in bytes; latched on accepted start
- busy  out  1  high in every state except IDLE
- s_valid  in  1  input byte valid
- s_data  in  W  input byte
- s_ready  out  1  input byte accepted when s_valid & s_ready
- dp_issue  out  1  datapath strobe, equal to input handshake
- dp_in  out  W  byte to datapath (= s_data)
- dp_sel  out  1  datapath mode select (= latched mode)
- dp_out  in  W  datapath result, valid DP_LAT cycles after issue
- dp_eq  in  1  datapath MAC-compare flag, aligned with dp_out
- m_valid  out  1  output FIFO non-empty
- m_data  out  W  FIFO head byte
- m_ready  in  1  consumer pop when m_valid & m_ready
- done  out  1  one-cycle completion pulse
- mac_ok  out  1  frame MAC result, held until next accepted start
- len_err  out  1  illegal length flag, held until next accepted start
- valid_key  out  1  sticky: set at done with mac_ok=1; cleared by reset or by done with mac_ok=0

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all counters, delay line and FIFO cleared; busy, s_ready, dp_issue, m_valid, done, mac_ok, len_err and valid_key all 0.
- States:
  - IDLE: on start, latch mode and len. If len==0 or len>MAX_LEN, go to DONE with len_err=1 and mac_ok=0. Otherwise go to RUN with issued=0, retired=0, acc_eq=1.
  - RUN: s_ready = (issued<len) & (fifo_count+inflight < FIFO_DEPTH). On handshake, issued++. When issued==len, go to DRAIN.
  - DRAIN: s_ready=0. Stay until retired==len and the FIFO is empty, then go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE. mac_ok = mode ? 1 : acc_eq; it is registered on entry to DONE.
- Delay line: a DP_LAT-deep shift register carries dp_issue.
  - At its tap (cycle c+DP_LAT for an issue in cycle c), dp_out is written into the FIFO at that clock edge and retired++.
  - In decrypt mode, acc_eq &= dp_eq at the same edge. In encrypt mode dp_eq is ignored.
- Latency: input handshake in cycle c gives m_valid=1 with that byte in cycle c+DP_LAT+1 (empty FIFO, no backpressure). Byte order is preserved.
- inflight = count of set bits in the delay line. The credit rule guarantees the FIFO never overflows. A write to a full FIFO is a design error and must not occur.
- Simultaneous FIFO push and pop: count is unchanged and both take effect. A pop from an empty FIFO is ignored.
- start while busy: ignored, no effect.
- m_ready low for any duration: issue stalls via credit. The delay line continues to drain into the FIFO.
- Decrypt frame: output bytes are passed to the FIFO regardless of dp_eq. Validity is reported only through mac_ok and valid_key.
- Reset asserted mid-frame: immediate return to IDLE with FIFO contents discarded. No done pulse is generated.
- Counters are 6 bits wide and never wrap (bounded by len ≤ MAX_LEN).

Test Plan:
- Encrypt, len=4, bytes 0x11,0x22,0x33,0x44, m_ready=1, model returns input^0xFF with DP_LAT=2 → first m_valid 3 cycles after the first handshake; m_data 0xEE,0xDD,0xCC,0xBB in order; done pulses once; mac_ok=1; valid_key=1.
- Decrypt, len=3, dp_eq=1,0,1 → three bytes output; mac_ok=0; valid_key cleared at done.
- Backpressure: len=8 with m_ready=0 → at most FIFO_DEPTH bytes accepted (fifo_count+inflight ≤4, s_ready=0 thereafter). Then release m_ready → all 8 bytes out in order, no loss or duplication, done follows the last pop.
- Illegal lengths: len=0, then len=33 → no s_ready; done one cycle after start; len_err=1; mac_ok=0; busy high for exactly 1 cycle.
- reset_n pulsed low mid-RUN after 2 of 5 bytes → all outputs 0 immediately. A new encrypt frame with len=1 then completes normally.
- start held high during RUN and DRAIN → ignored; exactly one done per accepted frame.

Source files
------------

// File: rtl/mte_frame_sequencer.sv
// mte_frame_sequencer: sequences one MAC-then-encrypt frame through the byte datapath.
// Input bytes are issued under credit control. Results return DP_LAT cycles later and
// are buffered in a small output FIFO. The per-byte MAC-compare flags are ANDed together
// to produce the frame verdict.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; len/mode latched on accept
// S_RUN   | issuing input bytes while FIFO credit remains
// S_DRAIN | all bytes issued; waiting for retire and an empty FIFO
// S_DONE  | one-cycle completion pulse; mac_ok/valid_key already updated
module mte_frame_sequencer #(
  parameter int W          = 8,
  parameter int MAX_LEN    = 32,
  parameter int DP_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic         mode,
  input  logic [5:0]   len,
  output logic         busy,
  input  logic         s_valid,
  input  logic [W-1:0] s_data,
  output logic         s_ready,
  output logic         dp_issue,
  output logic [W-1:0] dp_in,
  output logic         dp_sel,
  input  logic [W-1:0] dp_out,
  input  logic         dp_eq,
  output logic         m_valid,
  output logic [W-1:0] m_data,
  input  logic         m_ready,
  output logic         done,
  output logic         mac_ok,
  output logic         len_err,
  output logic         valid_key
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + DP_LAT + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          r_state;
  logic            r_mode;
  logic [5:0]      r_len;
  logic [5:0]      r_issued;
  logic [5:0]      r_retired;
  logic            r_acc_eq;
  logic            r_mac_ok;
  logic            r_len_err;
  logic            r_valid_key;
  logic [DP_LAT-1:0] r_dl;
  logic [W-1:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic [CW-1:0]   w_inflight;
  logic            w_hs;
  logic            w_tap;
  logic            w_pop;
  logic            w_len_bad;

  assign w_tap     = r_dl[DP_LAT-1];
  assign w_pop     = (r_count != '0) && m_ready;
  assign w_len_bad = (len == 6'd0) || (len > 6'(MAX_LEN));

  // Bytes in flight inside the datapath; they already own a FIFO slot.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < DP_LAT; i++) w_inflight = w_inflight + CW'(r_dl[i]);
  end

  assign s_ready   = (r_state == S_RUN) && (r_issued < r_len) &&
                     ((r_count + w_inflight) < CW'(FIFO_DEPTH));
  assign w_hs      = s_valid && s_ready;
  assign dp_issue  = w_hs;
  assign dp_in     = s_data;
  assign dp_sel    = r_mode;
  assign m_valid   = (r_count != '0);
  assign m_data    = r_mem[r_rd_ptr];
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign mac_ok    = r_mac_ok;
  assign len_err   = r_len_err;
  assign valid_key = r_valid_key;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Issue delay line: its tap marks the cycle dp_out holds a result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_dl <= '0;
    end else begin
      r_dl[0] <= w_hs;
      for (int i = 1; i < DP_LAT; i++) r_dl[i] <= r_dl[i-1];
    end
  end

  // FIFO storage; contents are only meaningful under the count.
  always_ff @(posedge clock) begin
    if (w_tap) r_mem[r_wr_ptr] <= dp_out;
  end

  // FIFO pointers and occupancy; push comes from the tap, pop from the consumer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_tap) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_tap, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Frame FSM with retire accounting and registered status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_mode      <= 1'b0;
      r_len       <= '0;
      r_issued    <= '0;
      r_retired   <= '0;
      r_acc_eq    <= 1'b1;
      r_mac_ok    <= 1'b0;
      r_len_err   <= 1'b0;
      r_valid_key <= 1'b0;
    end else begin
      if (w_tap) begin
        r_retired <= r_retired + 6'd1;
        if (!r_mode) r_acc_eq <= r_acc_eq & dp_eq;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode    <= mode;
            r_len     <= len;
            r_issued  <= '0;
            r_retired <= '0;
            r_acc_eq  <= 1'b1;
            r_mac_ok  <= 1'b0;
            if (w_len_bad) begin
              r_len_err   <= 1'b1;
              r_valid_key <= 1'b0;
              r_state     <= S_DONE;
            end else begin
              r_len_err <= 1'b0;
              r_state   <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_hs) begin
            r_issued <= r_issued + 6'd1;
            if ((r_issued + 6'd1) == r_len) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((r_retired == r_len) && (r_count == '0)) begin
            r_mac_ok    <= r_mode | r_acc_eq;
            r_valid_key <= r_mode | r_acc_eq;
            r_state     <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mte_frame_sequencer.sv
// Directed bench for mte_frame_sequencer with a behavioural datapath (inverts the byte, DP_LAT=2).
module tb_mte_frame_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start, mode;
  logic [5:0] len;
  logic       busy;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready, dp_issue, dp_sel;
  logic [7:0] dp_in, dp_out;
  logic       dp_eq;
  logic       m_valid, m_ready;
  logic [7:0] m_data;
  logic       done, mac_ok, len_err, valid_key;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] tx [64];
  logic       eq_tab [64];
  logic       drv_eq;
  logic [7:0] pd [2];
  logic       pe [2];

  mte_frame_sequencer #(.W(8), .MAX_LEN(32), .DP_LAT(2), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .mode(mode), .len(len),
    .busy(busy), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .dp_issue(dp_issue), .dp_in(dp_in), .dp_sel(dp_sel), .dp_out(dp_out),
    .dp_eq(dp_eq), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .done(done), .mac_ok(mac_ok), .len_err(len_err), .valid_key(valid_key)
  );

  always #5 clock = ~clock;

  // Datapath model: result = byte ^ 0xFF, eq flag from the bench table, two cycles later.
  always @(posedge clock) begin
    pd[0] <= dp_in ^ 8'hFF;
    pe[0] <= drv_eq;
    pd[1] <= pd[0];
    pe[1] <= pe[0];
  end
  assign dp_out = pd[1];
  assign dp_eq  = pe[1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_frame(input string nm, input logic md, input logic [5:0] ln,
                           input int stall, input bit hold_start, input logic exp_mac);
    int sent = 0, recv = 0, acc_stall = 0, done_cnt = 0;
    int hs_first = -1, mv_first = -1, done_cyc = 0, last_pop = -1;
    bit fin = 0;
    @(negedge clock);
    start = 1'b1; mode = md; len = ln;
    @(negedge clock);
    if (!hold_start) start = 1'b0;
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    chk({nm, "_dp_sel"}, 32'(dp_sel), 32'(md));
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      s_valid = (sent < int'(ln));
      s_data  = tx[sent];
      drv_eq  = eq_tab[sent];
      m_ready = (cyc >= stall);
      if (done_cnt > 0) start = 1'b0;
      #1;
      if (stall > 0 && cyc == stall - 1) chk({nm, "_bp_sready"}, 32'(s_ready), 32'd0);
      if (s_valid && s_ready) begin
        if (hs_first < 0) hs_first = cyc;
        if (cyc < stall) acc_stall++;
        sent++;
      end
      if (m_valid && mv_first < 0) mv_first = cyc;
      if (m_valid && m_ready) begin
        chk({nm, "_data"}, 32'(m_data), 32'(tx[recv] ^ 8'hFF));
        recv++;
        last_pop = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (done_cnt > 0 && cyc >= done_cyc + 3) fin = 1;
      @(negedge clock);
    end
    s_valid = 1'b0;
    start   = 1'b0;
    if (!fin) chk({nm, "_timeout"}, 32'd0, 32'd1);
    chk({nm, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({nm, "_recv"}, 32'(recv), 32'(ln));
    chk({nm, "_mac_ok"}, 32'(mac_ok), 32'(exp_mac));
    chk({nm, "_valid_key"}, 32'(valid_key), 32'(exp_mac));
    chk({nm, "_len_err"}, 32'(len_err), 32'd0);
    chk({nm, "_idle"}, 32'(busy), 32'd0);
    if (stall == 0) chk({nm, "_latency"}, 32'(mv_first - hs_first), 32'd3);
    if (stall > 0) begin
      chk({nm, "_bp_accepted"}, 32'(acc_stall), 32'd4);
      chk({nm, "_done_after_pop"}, 32'(done_cyc > last_pop), 32'd1);
    end
  endtask

  task automatic illegal(input string nm, input logic [5:0] ln);
    @(negedge clock);
    start = 1'b1; mode = 1'b1; len = ln;
    @(negedge clock);
    start = 1'b0;
    #1;
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_len_err"}, 32'(len_err), 32'd1);
    chk({nm, "_mac_ok"}, 32'(mac_ok), 32'd0);
    chk({nm, "_sready"}, 32'(s_ready), 32'd0);
    @(negedge clock);
    #1;
    chk({nm, "_busy2"}, 32'(busy), 32'd0);
    chk({nm, "_done2"}, 32'(done), 32'd0);
    chk({nm, "_len_err_held"}, 32'(len_err), 32'd1);
    chk({nm, "_valid_key"}, 32'(valid_key), 32'd0);
  endtask

  initial begin
    int sent;
    for (int i = 0; i < 64; i++) begin
      tx[i]     = 8'((i + 1) * 17);
      eq_tab[i] = 1'b1;
    end
    reset_n = 1'b0; start = 1'b0; mode = 1'b0; len = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0; drv_eq = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sready", 32'(s_ready), 32'd0);
    chk("rst_mvalid", 32'(m_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mac_ok", 32'(mac_ok), 32'd0);
    chk("rst_len_err", 32'(len_err), 32'd0);
    chk("rst_valid_key", 32'(valid_key), 32'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    run_frame("enc4", 1'b1, 6'd4, 0, 0, 1'b1);

    eq_tab[1] = 1'b0;
    run_frame("dec3_bad", 1'b0, 6'd3, 0, 0, 1'b0);
    eq_tab[1] = 1'b1;
    run_frame("dec2_good", 1'b0, 6'd2, 0, 0, 1'b1);

    run_frame("bp8", 1'b1, 6'd8, 20, 0, 1'b1);

    illegal("len0", 6'd0);
    illegal("len33", 6'd33);

    for (int i = 0; i < 64; i++) eq_tab[i] = 1'b0;
    run_frame("enc_hold", 1'b1, 6'd5, 0, 1, 1'b1);
    for (int i = 0; i < 64; i++) eq_tab[i] = 1'b1;

    @(negedge clock);
    start = 1'b1; mode = 1'b1; len = 6'd5;
    @(negedge clock);
    start = 1'b0;
    sent = 0;
    for (int c = 0; c < 20 && sent < 2; c++) begin
      s_valid = 1'b1; s_data = tx[sent]; m_ready = 1'b1;
      #1;
      if (s_valid && s_ready) sent++;
      @(negedge clock);
    end
    s_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_sready", 32'(s_ready), 32'd0);
    chk("midrst_issue", 32'(dp_issue), 32'd0);
    chk("midrst_mvalid", 32'(m_valid), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_mac_ok", 32'(mac_ok), 32'd0);
    chk("midrst_valid_key", 32'(valid_key), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    #1;
    chk("midrst_mvalid_after", 32'(m_valid), 32'd0);
    run_frame("after_rst", 1'b1, 6'd1, 0, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
